// File: rtl/vector_draw_engine_pkg.sv
// Shared definitions for the vector draw engine: DAC channel codes, FSM states, point-record sizing.
package vector_draw_engine_pkg;

    localparam logic [1:0] CH_X = 2'd0;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_Z = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT_X,
        ST_EMIT_Y,
        ST_EMIT_Z,
        ST_DWELL
    } state_t;

    // A queued point is packed as {blank, z, y, x}.
    function automatic int point_width(input int w, input int zw);
        return 1 + zw + 2 * w;
    endfunction

endpackage

// File: rtl/vector_draw_engine_line_stepper.sv
// Bresenham core: load applies the first step of a new line at once, step advances one position.
module vector_draw_engine_line_stepper #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic         blank,
    input  logic [W-1:0] end_x,
    input  logic [W-1:0] end_y,
    output logic [W-1:0] nxt_x,
    output logic [W-1:0] cur_y,
    output logic         last
);
    localparam int EW = W + 2;

    logic [W-1:0] cur_x_reg, cur_y_reg, tgt_x_reg, tgt_y_reg, dx_reg, dy_reg;
    logic         sx_neg_reg, sy_neg_reg;
    logic signed [EW-1:0] err_reg;

    logic [W-1:0] cur_x_next, cur_y_next, ld_dx, ld_dy, s_dx, s_dy, st_x, st_y;
    logic         ld_sx_neg, ld_sy_neg, s_sx_neg, s_sy_neg;
    logic signed [EW-1:0] err_next, ld_err, s_err, st_err, s_dx_s, s_dy_s, e2;

    always_comb begin
        ld_sx_neg = end_x < cur_x_reg;
        ld_sy_neg = end_y < cur_y_reg;
        ld_dx     = ld_sx_neg ? cur_x_reg - end_x : end_x - cur_x_reg;
        ld_dy     = ld_sy_neg ? cur_y_reg - end_y : end_y - cur_y_reg;
        ld_err    = $signed({2'b00, ld_dx}) - $signed({2'b00, ld_dy});

        // On load the freshly computed slope feeds the step logic directly.
        s_dx     = load ? ld_dx : dx_reg;
        s_dy     = load ? ld_dy : dy_reg;
        s_sx_neg = load ? ld_sx_neg : sx_neg_reg;
        s_sy_neg = load ? ld_sy_neg : sy_neg_reg;
        s_err    = load ? ld_err : err_reg;
        s_dx_s   = $signed({2'b00, s_dx});
        s_dy_s   = $signed({2'b00, s_dy});
        e2       = s_err <<< 1;

        st_x   = cur_x_reg;
        st_y   = cur_y_reg;
        st_err = s_err;
        if (e2 > -s_dy_s) begin
            st_err = st_err - s_dy_s;
            st_x   = s_sx_neg ? cur_x_reg - W'(1) : cur_x_reg + W'(1);
        end
        if (e2 < s_dx_s) begin
            st_err = st_err + s_dx_s;
            st_y   = s_sy_neg ? cur_y_reg - W'(1) : cur_y_reg + W'(1);
        end

        cur_x_next = cur_x_reg;
        cur_y_next = cur_y_reg;
        err_next   = err_reg;
        if (load) begin
            err_next = ld_err;
            if (blank) begin
                cur_x_next = end_x;
                cur_y_next = end_y;
            end else if (ld_dx != '0 || ld_dy != '0) begin
                cur_x_next = st_x;
                cur_y_next = st_y;
                err_next   = st_err;
            end
        end else if (step) begin
            cur_x_next = st_x;
            cur_y_next = st_y;
            err_next   = st_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_x_reg  <= '0;
            cur_y_reg  <= '0;
            tgt_x_reg  <= '0;
            tgt_y_reg  <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
            err_reg    <= '0;
        end else begin
            cur_x_reg <= cur_x_next;
            cur_y_reg <= cur_y_next;
            err_reg   <= err_next;
            if (load) begin
                tgt_x_reg  <= end_x;
                tgt_y_reg  <= end_y;
                dx_reg     <= ld_dx;
                dy_reg     <= ld_dy;
                sx_neg_reg <= ld_sx_neg;
                sy_neg_reg <= ld_sy_neg;
            end
        end
    end

    assign nxt_x = cur_x_next;
    assign cur_y = cur_y_reg;
    assign last  = (cur_x_reg == tgt_x_reg) && (cur_y_reg == tgt_y_reg);

endmodule

// File: rtl/vector_draw_engine.sv
// Point FIFO, sequencing FSM, X/Y/Z DAC word mux and dwell counter around the Bresenham stepper.
module vector_draw_engine
    import vector_draw_engine_pkg::*;
#(
    parameter int W     = 12,
    parameter int ZW    = 8,
    parameter int DEPTH = 8,
    parameter int DWELL = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pt_valid,
    output logic                       pt_ready,
    input  logic [W-1:0]               pt_x,
    input  logic [W-1:0]               pt_y,
    input  logic [ZW-1:0]              pt_z,
    input  logic                       pt_blank,
    output logic                       dac_valid,
    input  logic                       dac_ready,
    output logic [1:0]                 dac_chan,
    output logic [W-1:0]               dac_value,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int LW  = $clog2(DEPTH + 1);
    localparam int PW  = $clog2(DEPTH);
    localparam int PTW = point_width(W, ZW);
    localparam int DCW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    logic [PTW-1:0] fifo_mem [DEPTH];
    logic [PTW-1:0] rd_data_reg;
    logic [PW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]  level_reg;
    logic           ready_en_reg;

    state_t         state_reg;
    logic           dac_valid_reg;
    logic [1:0]     dac_chan_reg;
    logic [W-1:0]   dac_value_reg;
    logic [DCW-1:0] dwell_cnt_reg;
    logic [ZW-1:0]  cmd_z_reg;
    logic           cmd_blank_reg;

    logic           push, pop, pos_done, advance, last;
    logic [W-1:0]   nxt_x, cur_y, z_word;

    assign push = pt_valid && pt_ready;
    assign pop  = (state_reg == ST_LOAD);

    // Head entry is read every cycle so it is ready by the time LOAD consumes it.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= {pt_blank, pt_z, pt_y, pt_x};
        rd_data_reg <= fifo_mem[rd_ptr_reg];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push && !pop)
                level_reg <= level_reg + LW'(1);
            else if (pop && !push)
                level_reg <= level_reg - LW'(1);
        end
    end

    vector_draw_engine_line_stepper #(.W(W)) u_stepper (
        .clk   (clk),
        .reset (reset),
        .load  (pop),
        .step  (advance),
        .blank (rd_data_reg[PTW-1]),
        .end_x (rd_data_reg[W-1:0]),
        .end_y (rd_data_reg[2*W-1:W]),
        .nxt_x (nxt_x),
        .cur_y (cur_y),
        .last  (last)
    );

    always_comb begin
        z_word = '0;
        if (!cmd_blank_reg)
            z_word[W-1 -: ZW] = cmd_z_reg;
    end

    // A position is finished when its Z word leaves (no dwell) or the dwell count expires.
    assign pos_done = (state_reg == ST_EMIT_Z && dac_ready && DWELL == 0) ||
                      (state_reg == ST_DWELL && dwell_cnt_reg == '0);
    assign advance  = pos_done && !last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            dac_valid_reg <= 1'b0;
            dac_chan_reg  <= CH_X;
            dac_value_reg <= '0;
            dwell_cnt_reg <= '0;
            cmd_z_reg     <= '0;
            cmd_blank_reg <= 1'b0;
            ready_en_reg  <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (pos_done) begin
                if (!last) begin
                    state_reg     <= ST_EMIT_X;
                    dac_valid_reg <= 1'b1;
                    dac_chan_reg  <= CH_X;
                    dac_value_reg <= nxt_x;
                end else begin
                    dac_valid_reg <= 1'b0;
                    state_reg     <= (level_reg != '0) ? ST_LOAD : ST_IDLE;
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (level_reg != '0)
                            state_reg <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        cmd_z_reg     <= rd_data_reg[2*W+ZW-1:2*W];
                        cmd_blank_reg <= rd_data_reg[PTW-1];
                        state_reg     <= ST_EMIT_X;
                        dac_valid_reg <= 1'b1;
                        dac_chan_reg  <= CH_X;
                        dac_value_reg <= nxt_x;
                    end
                    ST_EMIT_X: begin
                        if (dac_ready) begin
                            state_reg     <= ST_EMIT_Y;
                            dac_chan_reg  <= CH_Y;
                            dac_value_reg <= cur_y;
                        end
                    end
                    ST_EMIT_Y: begin
                        if (dac_ready) begin
                            state_reg     <= ST_EMIT_Z;
                            dac_chan_reg  <= CH_Z;
                            dac_value_reg <= z_word;
                        end
                    end
                    ST_EMIT_Z: begin
                        if (dac_ready) begin
                            state_reg     <= ST_DWELL;
                            dac_valid_reg <= 1'b0;
                            dwell_cnt_reg <= DCW'(DWELL - 1);
                        end
                    end
                    ST_DWELL: dwell_cnt_reg <= dwell_cnt_reg - DCW'(1);
                    default:  state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign pt_ready   = ready_en_reg && (level_reg != LW'(DEPTH));
    assign dac_valid  = dac_valid_reg;
    assign dac_chan   = dac_chan_reg;
    assign dac_value  = dac_value_reg;
    assign busy       = (state_reg != ST_IDLE) || (level_reg != '0);
    assign fifo_level = level_reg;

endmodule
